// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with binary wrap-bit pointers, occupancy/threshold flags,
// optional first-word-fall-through read port, synchronous flush and sticky errors.
module fifo_sync_flex #(
   parameter int FIFO_data_size = 8,
   parameter int FIFO_addr_size = 4,
   parameter bit FWFT           = 1'b0,
   parameter int AF_THRESH      = 14,
   parameter int AE_THRESH      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      w_en,
   input  logic [FIFO_data_size-1:0] data_in,
   input  logic                      r_en,
   output logic [FIFO_data_size-1:0] data_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [FIFO_addr_size:0]   count,
   output logic                      overflow,
   output logic                      underflow
);
   localparam int DEPTH = 1 << FIFO_addr_size;
   localparam logic [FIFO_addr_size:0] AF_T = (FIFO_addr_size+1)'(AF_THRESH);
   localparam logic [FIFO_addr_size:0] AE_T = (FIFO_addr_size+1)'(AE_THRESH);

   logic [FIFO_data_size-1:0] mem [DEPTH];
   logic [FIFO_addr_size:0]   w_ptr, r_ptr;
   logic                      wr_ok, rd_ok;

   assign count        = w_ptr - r_ptr;
   assign empty        = (w_ptr == r_ptr);
   assign full         = (w_ptr[FIFO_addr_size] != r_ptr[FIFO_addr_size]) &&
                         (w_ptr[FIFO_addr_size-1:0] == r_ptr[FIFO_addr_size-1:0]);
   assign almost_full  = (count >= AF_T);
   assign almost_empty = (count <= AE_T);

   // Flush and reset swallow both requests; full/empty gating forbids write- or read-through.
   assign wr_ok = rst && !clr && w_en && !full;
   assign rd_ok = rst && !clr && r_en && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[w_ptr[FIFO_addr_size-1:0]] <= data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) w_ptr <= w_ptr + 1'b1;
         if (rd_ok) r_ptr <= r_ptr + 1'b1;
         if (w_en && full)  overflow  <= 1'b1;
         if (r_en && empty) underflow <= 1'b1;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out = mem[r_ptr[FIFO_addr_size-1:0]];
      end else begin : g_std
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)       data_out <= '0;
            else if (rd_ok) data_out <= mem[r_ptr[FIFO_addr_size-1:0]];
         end
      end
   endgenerate
endmodule

// File: tb/tb_fifo_sync_flex.sv
// Drives a standard-read and an FWFT instance with the same stimulus and checks
// both against a queue model every cycle, plus literal expectations per scenario.
module tb_fifo_sync_flex;
   localparam int DW = 8, AW = 4, DEPTH = 16, AF = 14, AE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout_s, dout_f;
   logic full_s, empty_s, af_s, ae_s, ov_s, un_s;
   logic full_f, empty_f, af_f, ae_f, ov_f, un_f;
   logic [AW:0] cnt_s, cnt_f;

   int total = 0, bad = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   bit m_ov = 1'b0, m_un = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_flex #(.FIFO_data_size(DW), .FIFO_addr_size(AW), .FWFT(1'b0),
                    .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
      .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
      .almost_empty(ae_s), .count(cnt_s), .overflow(ov_s), .underflow(un_s));

   fifo_sync_flex #(.FIFO_data_size(DW), .FIFO_addr_size(AW), .FWFT(1'b1),
                    .AF_THRESH(AF), .AE_THRESH(AE)) u_fw (
      .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
      .almost_empty(ae_f), .count(cnt_f), .overflow(ov_f), .underflow(un_f));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a bounded queue plus sticky flags.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete(); m_ov = 1'b0; m_un = 1'b0; m_dout = '0;
      end else if (clr) begin
         q.delete(); m_ov = 1'b0; m_un = 1'b0;
      end else begin
         automatic int sz = q.size();
         if (w_en && sz == DEPTH) m_ov = 1'b1;
         if (r_en && sz == 0)     m_un = 1'b1;
         if (r_en && sz > 0)      m_dout = q.pop_front();
         if (w_en && sz < DEPTH)  q.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         automatic int sz = q.size();
         chk("s_count", 32'(cnt_s), 32'(sz));
         chk("s_empty", 32'(empty_s), 32'(sz == 0));
         chk("s_full",  32'(full_s),  32'(sz == DEPTH));
         chk("s_af",    32'(af_s),    32'(sz >= AF));
         chk("s_ae",    32'(ae_s),    32'(sz <= AE));
         chk("s_ov",    32'(ov_s),    32'(m_ov));
         chk("s_un",    32'(un_s),    32'(m_un));
         chk("s_dout",  32'(dout_s),  32'(m_dout));
         chk("f_count", 32'(cnt_f), 32'(sz));
         chk("f_empty", 32'(empty_f), 32'(sz == 0));
         chk("f_full",  32'(full_f),  32'(sz == DEPTH));
         chk("f_af",    32'(af_f),    32'(sz >= AF));
         chk("f_ae",    32'(ae_f),    32'(sz <= AE));
         chk("f_ov",    32'(ov_f),    32'(m_ov));
         chk("f_un",    32'(un_f),    32'(m_un));
         if (sz > 0) chk("f_dout", 32'(dout_f), 32'(q[0]));
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, 32'(cnt_s), 0);
      chk({tag, "_empty"}, 32'(empty_s), 1);
      chk({tag, "_ae"},    32'(ae_s), 1);
      chk({tag, "_full"},  32'(full_s), 0);
      chk({tag, "_af"},    32'(af_s), 0);
      chk({tag, "_ov"},    32'(ov_s), 0);
      chk({tag, "_un"},    32'(un_s), 0);
      chk({tag, "_dout"},  32'(dout_s), 0);
      chk({tag, "_fcount"}, 32'(cnt_f), 0);
      chk({tag, "_fempty"}, 32'(empty_f), 1);
   endtask

   initial begin
      #2 rst = 1'b0;
      #20;
      chk_reset_vals("rst");
      chk_en = 1'b1;
      cyc(); rst = 1'b1;

      // Fill with 0x00..0x0F.
      w_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 8'(i);
         cyc();
         chk("fill_af", 32'(af_s), 32'(i + 1 >= 14));
      end
      chk("fill_full", 32'(full_s), 1);
      chk("fill_count", 32'(cnt_s), 16);
      chk("fill_ov", 32'(ov_s), 0);

      data_in = 8'hAA;
      cyc();
      w_en = 1'b0;
      chk("ovf_flag", 32'(ov_s), 1);
      chk("ovf_count", 32'(cnt_s), 16);

      r_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("fw_head", 32'(dout_f), 32'(i));
         cyc();
         chk("rd_data", 32'(dout_s), 32'(i));
      end
      r_en = 1'b0;
      chk("drain_empty", 32'(empty_s), 1);

      // Concurrent traffic at count=3 across two pointer wraps.
      w_en = 1'b1;
      for (int i = 0; i < 3; i++) begin data_in = 8'(8'h30 + i); cyc(); end
      r_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         data_in = 8'(8'h40 + i);
         cyc();
         chk("cc_count", 32'(cnt_s), 3);
         chk("cc_data", 32'(dout_s), (i < 3) ? 32'(8'h30 + i) : 32'(8'h40 + i - 3));
      end
      w_en = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      r_en = 1'b0;
      chk("cc_drained", 32'(empty_s), 1);

      // FWFT head visibility, pop, then underflow.
      w_en = 1'b1; data_in = 8'h5C; cyc(); w_en = 1'b0;
      chk("fw_data", 32'(dout_f), 32'h5C);
      chk("fw_nempty", 32'(empty_f), 0);
      r_en = 1'b1; cyc(); r_en = 1'b0;
      chk("fw_pop_empty", 32'(empty_f), 1);
      r_en = 1'b1; cyc(); r_en = 1'b0;
      chk("fw_underflow", 32'(un_f), 1);

      // Flush at count=9 with both requests active.
      w_en = 1'b1;
      for (int i = 0; i < 9; i++) begin data_in = 8'(8'h90 + i); cyc(); end
      chk("pre_clr_count", 32'(cnt_s), 9);
      clr = 1'b1; r_en = 1'b1; data_in = 8'hEE; cyc();
      clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
      chk("clr_count", 32'(cnt_s), 0);
      chk("clr_empty", 32'(empty_s), 1);
      chk("clr_ov", 32'(ov_s), 0);
      chk("clr_un", 32'(un_s), 0);
      chk("clr_dout_hold", 32'(dout_s), 32'h5C);

      // Build count=7 with overflow set, then reset mid-cycle.
      w_en = 1'b1;
      for (int i = 0; i < 17; i++) begin data_in = 8'(8'hB0 + i); cyc(); end
      w_en = 1'b0;
      r_en = 1'b1;
      for (int i = 0; i < 9; i++) cyc();
      r_en = 1'b0;
      chk("pre_rst_count", 32'(cnt_s), 7);
      chk("pre_rst_ov", 32'(ov_s), 1);
      chk("pre_rst_dout", 32'(dout_s), 32'hB8);
      w_en = 1'b1; r_en = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk_reset_vals("arst");
      w_en = 1'b0; r_en = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      cyc(); cyc();
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
